// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage. It holds the PC and issues word reads on the memory
// fetch port. Returned instructions are buffered in a small prefetch FIFO and
// handed to decode with a valid/ready handshake. Execute can redirect fetch
// on branches, jumps and traps.
//
// Parameters
//   RESET_PC    PC after reset (bits [1:0] ignored)
//   FIFO_DEPTH  prefetch entries; must be a power of 2 and at least 2
//
// Ports
//   clk             clock
//   reset_n         asynchronous reset, active low
//   fe_req          fetch read request to memory
//   fe_addr[29:0]   word address [31:2] of the request
//   fe_ack          request accepted this cycle (same-cycle)
//   fe_error        access fault for the requested address (same-cycle)
//   fe_data[31:0]   read data, valid in the cycle after fe_req & fe_ack
//   redirect_valid  flush and restart fetch at redirect_pc
//   redirect_pc     new PC (bits [1:0] ignored)
//   de_valid        FIFO head holds an instruction for decode
//   de_ready        decode accepts the head this cycle
//   de_pc[31:0]     PC of the head entry
//   de_insn[31:0]   instruction word of the head entry (0 when de_error)
//   de_error        head entry faulted on fetch
//   stall_cycles    (only with FETCH_STALL_CNT_EN) count of fe_req & ~fe_ack
//
// Optional feature macro: FETCH_STALL_CNT_EN adds the saturating stall_cycles
// counter and its output port.
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        fe_req,
  output logic [29:0] fe_addr,
  input  logic        fe_ack,
  input  logic        fe_error,
  input  logic [31:0] fe_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        de_valid,
  input  logic        de_ready,
  output logic [31:0] de_pc,
  output logic [31:0] de_insn,
  output logic        de_error
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    RUN  = 1'b0,  // issuing fetches
    HALT = 1'b1   // a faulting fetch was accepted; wait for a redirect
  } state_t;

  state_t            state;
  logic [29:0]       pc;
  logic              inflight;   // a request was accepted last cycle
  logic [29:0]       ipc;        // address of the in-flight request
  logic              ierr;       // in-flight request faulted

  logic [29:0]       fifo_pc   [FIFO_DEPTH];
  logic [31:0]       fifo_insn [FIFO_DEPTH];
  logic              fifo_err  [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic [CNT_W:0]    occupancy;
  logic              has_room;
  logic              accept;
  logic              push;
  logic              pop;

  // The low PC bits are don't-care here; execute owns alignment checking.
  logic              unused_pc_bits;
  assign unused_pc_bits = ^redirect_pc[1:0];

  // NOTE: every signal written in this always_comb gets a value on every path
  // (defaults first), so no latch can be inferred.
  always_comb begin
    // Room must also be reserved for the response already in flight, which
    // is what keeps the FIFO from ever overflowing.
    occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    has_room  = occupancy < (CNT_W+1)'(FIFO_DEPTH);
    // reset_n gates the request so that memory sees no request while reset
    // is held, yet fetch starts in the very first cycle after release.
    fe_req    = reset_n & (state == RUN) & ~redirect_valid & has_room;
    fe_addr   = pc;
    accept    = fe_req & fe_ack;
    // A redirect drops the in-flight response and ignores a same-cycle pop.
    push      = inflight & ~redirect_valid;
    de_valid  = (count != '0);
    pop       = de_valid & de_ready & ~redirect_valid;
    de_pc     = '0;
    de_insn   = '0;
    de_error  = 1'b0;
    if (de_valid) begin
      de_pc    = {fifo_pc[rd_ptr], 2'b00};
      de_insn  = fifo_insn[rd_ptr];
      de_error = fifo_err[rd_ptr];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RUN;
      pc       <= RESET_PC[31:2];
      inflight <= 1'b0;
      ipc      <= '0;
      ierr     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      state    <= RUN;
      pc       <= redirect_pc[31:2];
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= accept;
      if (accept) begin
        pc   <= pc + 30'd1;   // wraps 0x3FFF_FFFF -> 0
        ipc  <= pc;
        ierr <= fe_error;
        if (fe_error) begin
          state <= HALT;
        end
      end
      // Pointers wrap naturally because FIFO_DEPTH is a power of 2.
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the FIFO storage is deliberately not reset; an entry is only ever
  // read after it has been written, and the outputs are forced to zero while
  // the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= ipc;
      fifo_insn[wr_ptr] <= ierr ? 32'h0 : fe_data;
      fifo_err[wr_ptr]  <= ierr;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
    end else if (fe_req && !fe_ack && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage (RESET_PC = 0x100, FIFO_DEPTH = 4).
// A queue-based reference model tracks the expected FIFO contents, PC and
// halt status; a table covers start-up, hand-written sequences cover the
// multi-cycle corner cases, and a random phase stresses the rest.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fe_req;
  logic [29:0] fe_addr;
  logic        fe_ack;
  logic        fe_error;
  logic [31:0] fe_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        de_valid;
  logic        de_ready;
  logic [31:0] de_pc;
  logic [31:0] de_insn;
  logic        de_error;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fe_req         (fe_req),
    .fe_addr        (fe_addr),
    .fe_ack         (fe_ack),
    .fe_error       (fe_error),
    .fe_data        (fe_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .de_valid       (de_valid),
    .de_ready       (de_ready),
    .de_pc          (de_pc),
    .de_insn        (de_insn),
    .de_error       (de_error)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  // Memory fault model: one faulting word address when enabled.
  logic        fault_on;
  logic [29:0] fault_addr;
  assign fe_error = fault_on && (fe_addr == fault_addr);

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return 32'hC0DE_0000 ^ {a, 2'b01};
  endfunction

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model
  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] insn;
    logic        err;
  } entry_t;

  entry_t      mq[$];
  logic [29:0] m_pc;
  logic        m_pend;
  entry_t      m_pend_e;
  logic        m_halt;

  // Values sampled from the DUT in the most recent cycle
  logic        s_req;
  logic [29:0] s_addr;
  logic        s_valid;
  logic [31:0] s_pc;
  logic [31:0] s_insn;
  logic        s_err;

  // One clock cycle: drive inputs, compare with the model mid-cycle, advance
  // the model, then deliver read data for an accepted request.
  task automatic cycle(input logic ack, input logic rdy, input logic redir,
                       input logic [31:0] rpc);
    logic        e_req;
    logic        e_err;
    logic        took;
    logic [29:0] took_addr;
    entry_t      e;
    fe_ack         = ack;
    de_ready       = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    @(negedge clk);
    s_req   = fe_req;
    s_addr  = fe_addr;
    s_valid = de_valid;
    s_pc    = de_pc;
    s_insn  = de_insn;
    s_err   = de_error;
    e_req = !m_halt && !redir && ((mq.size() + int'(m_pend)) < DEPTH);
    check("model_fe_req", s_req, e_req);
    check("model_fe_addr", s_addr, m_pc);
    check("model_de_valid", s_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("model_de_pc", s_pc, {mq[0].addr, 2'b00});
      check("model_de_insn", s_insn, mq[0].insn);
      check("model_de_error", s_err, mq[0].err);
    end
    took      = fe_req & fe_ack;
    took_addr = fe_addr;
    if (redir) begin
      mq.delete();
      m_pend = 1'b0;
      m_pc   = rpc[31:2];
      m_halt = 1'b0;
    end else begin
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (m_pend) begin
        check("fifo_no_overflow", 64'(mq.size() < DEPTH), 64'd1);
        mq.push_back(m_pend_e);
      end
      m_pend = e_req && ack;
      if (m_pend) begin
        e_err  = fault_on && (m_pc == fault_addr);
        e.addr = m_pc;
        e.insn = e_err ? 32'h0 : mem_word(m_pc);
        e.err  = e_err;
        m_pend_e = e;
        m_pc = m_pc + 30'd1;
        if (e_err) m_halt = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    fe_data = took ? mem_word(took_addr) : $urandom();
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    fe_ack         = 1'b0;
    de_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    fault_on       = 1'b0;
    fault_addr     = '0;
    fe_data        = 32'h0;
    @(negedge clk);
    check("reset_fe_req", fe_req, 0);
    check("reset_fe_addr", fe_addr, 30'h40);
    check("reset_de_valid", de_valid, 0);
    check("reset_de_pc", de_pc, 0);
    check("reset_de_insn", de_insn, 0);
    check("reset_de_error", de_error, 0);
`ifdef FETCH_STALL_CNT_EN
    check("reset_stall_cycles", stall_cycles, 0);
`endif
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mq.delete();
    m_pc   = RPC[31:2];
    m_pend = 1'b0;
    m_halt = 1'b0;
  endtask

  typedef struct {
    logic        ack;
    logic        rdy;
    logic [29:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[6];

  initial begin
    // Start-up sequence after reset with an always-accepting memory
    tbl[0] = '{1'b1, 1'b1, 30'h40, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 30'h41, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 30'h42, 1'b1, 32'h100};
    tbl[3] = '{1'b1, 1'b1, 30'h43, 1'b1, 32'h104};
    tbl[4] = '{1'b1, 1'b1, 30'h44, 1'b1, 32'h108};
    tbl[5] = '{1'b1, 1'b1, 30'h45, 1'b1, 32'h10C};

    // 1: reset release, streaming fetch
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].ack, tbl[i].rdy, 1'b0, 32'h0);
      check("t1_fe_addr", s_addr, tbl[i].exp_addr);
      check("t1_de_valid", s_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) check("t1_de_pc", s_pc, tbl[i].exp_pc);
    end

    // 2: decode stalled, FIFO fills, one pop gives one refill
    do_reset();
    repeat (8) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("t2_full_req", s_req, 0);
    check("t2_full_head", s_pc, 32'h100);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("t2_refill_req", s_req, 1);
    check("t2_refill_addr", s_addr, 30'h44);
    check("t2_new_head", s_pc, 32'h104);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("t2_full_again", s_req, 0);

    // 3: memory port busy for three cycles
    do_reset();
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      check("t3_addr_held", s_addr, 30'h43);
      check("t3_req_held", s_req, 1);
    end
    check("t3_drained", s_valid, 0);
`ifdef FETCH_STALL_CNT_EN
    check("t3_stall_cycles", stall_cycles, 3);
`endif

    // 4: redirect with a response in flight and two entries queued
    do_reset();
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("t4_queued", s_valid, 1);
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_2003);
    check("t4_redirect_req", s_req, 0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("t4_flushed", s_valid, 0);
    check("t4_restart_addr", s_addr, 30'h800);
    check("t4_restart_req", s_req, 1);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("t4_stale_dropped", s_valid, 0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("t4_new_pc", s_pc, 32'h2000);
    check("t4_new_insn", s_insn, mem_word(30'h800));

    // 5: access fault halts fetch until redirected
    do_reset();
    fault_on   = 1'b1;
    fault_addr = 30'h4000;
    cycle(1'b1, 1'b0, 1'b1, 32'h0001_0000);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("t5_fault_addr", s_addr, 30'h4000);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("t5_halted_req", s_req, 0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("t5_err_valid", s_valid, 1);
    check("t5_err_pc", s_pc, 32'h0001_0000);
    check("t5_err_flag", s_err, 1);
    check("t5_err_insn", s_insn, 0);
    check("t5_still_halted", s_req, 0);
    fault_on = 1'b0;
    cycle(1'b1, 1'b0, 1'b1, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("t5_resume_req", s_req, 1);
    check("t5_resume_addr", s_addr, 30'h0);

    // 6: PC wrap at the top of the address space
    do_reset();
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("t6_addr0", s_addr, 30'h3FFF_FFFE);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("t6_addr1", s_addr, 30'h3FFF_FFFF);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("t6_addr_wrap", s_addr, 30'h0);
    check("t6_pc0", s_pc, 32'hFFFF_FFF8);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("t6_pc1", s_pc, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("t6_pc_wrap", s_pc, 32'h0);

    // Random traffic against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic        r_ack;
      logic        r_rdy;
      logic        r_redir;
      logic [31:0] r_pc;
      r_ack   = ($urandom_range(0, 3) != 0);
      r_rdy   = ($urandom_range(0, 9) < 7);
      r_redir = ($urandom_range(0, 39) == 0);
      r_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF))
                                             : $urandom();
      if ($urandom_range(0, 59) == 0) begin
        fault_on   = 1'b1;
        fault_addr = m_pc + 30'($urandom_range(0, 5));
      end else if ($urandom_range(0, 29) == 0) begin
        fault_on = 1'b0;
      end
      cycle(r_ack, r_rdy, r_redir, r_pc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
